// File: rtl/dpram_arb_pkg.sv
// dpram_arb_pkg: shared widths and port-select encoding for the dual-port RAM arbiter.
package dpram_arb_pkg;
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;
  function automatic int addr_width(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
  function automatic int idx_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: picks the first two set request bits in round-robin order starting at ptr.
module rr_pick2 #(
  parameter int NREQ = 4,
  parameter int IW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   ga_idx,
  output logic [IW-1:0]   gb_idx,
  output logic [NREQ-1:0] ga_oh,
  output logic [NREQ-1:0] gb_oh,
  output logic            ga_vld,
  output logic            gb_vld
);
  logic [IW-1:0] j;
  always_comb begin
    ga_vld = 1'b0;
    gb_vld = 1'b0;
    ga_idx = '0;
    gb_idx = '0;
    j = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = IW'((int'(ptr) + k) % NREQ);
      if (req[j] && !ga_vld) begin
        ga_vld = 1'b1;
        ga_idx = j;
      end else if (req[j] && !gb_vld) begin
        gb_vld = 1'b1;
        gb_idx = j;
      end
    end
    ga_oh = ga_vld ? NREQ'(1) << ga_idx : '0;
    gb_oh = gb_vld ? NREQ'(1) << gb_idx : '0;
  end
endmodule

// File: rtl/dpram_port_arbiter.sv
// dpram_port_arbiter: grants up to two requesters per cycle onto RAM ports A/B and routes read data back.
module dpram_port_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  localparam int AW = addr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_we,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [NREQ*WIDTH-1:0] rsp_rdata,
  output logic                  ram_we_a,
  output logic [AW-1:0]         ram_addr_a,
  output logic [WIDTH-1:0]      ram_din_a,
  input  logic [WIDTH-1:0]      ram_dout_a,
  output logic                  ram_we_b,
  output logic [AW-1:0]         ram_addr_b,
  output logic [WIDTH-1:0]      ram_din_b,
  input  logic [WIDTH-1:0]      ram_dout_b
);
  localparam int IW = idx_width(NREQ);
  logic [IW-1:0] rr_ptr, ga, gb, last;
  logic [NREQ-1:0] ga_oh, gb_oh, pend, pend_port;
  logic ga_raw, gb_raw, ga_g, gb_g, conflict;
  logic [AW-1:0] addr_ga, addr_gb;
  rr_pick2 #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req(req_valid), .ptr(rr_ptr), .ga_idx(ga), .gb_idx(gb),
    .ga_oh(ga_oh), .gb_oh(gb_oh), .ga_vld(ga_raw), .gb_vld(gb_raw)
  );
  assign addr_ga = req_addr[int'(ga)*AW +: AW];
  assign addr_gb = req_addr[int'(gb)*AW +: AW];
  // a write on either side of a same-address pair pushes port B to a later cycle
  assign conflict = addr_ga == addr_gb && (req_we[ga] || req_we[gb]);
  assign ga_g = ga_raw && !rst;
  assign gb_g = gb_raw && !rst && !conflict;
  assign req_ready = (ga_g ? ga_oh : '0) | (gb_g ? gb_oh : '0);
  assign ram_we_a = ga_g && req_we[ga];
  assign ram_we_b = gb_g && req_we[gb];
  assign ram_addr_a = ga_g ? addr_ga : '0;
  assign ram_addr_b = gb_g ? addr_gb : '0;
  assign ram_din_a = ram_we_a ? req_wdata[int'(ga)*WIDTH +: WIDTH] : '0;
  assign ram_din_b = ram_we_b ? req_wdata[int'(gb)*WIDTH +: WIDTH] : '0;
  assign last = gb_g ? gb : ga;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      pend <= '0;
      pend_port <= '0;
    end else begin
      if (ga_g) rr_ptr <= (int'(last) == NREQ - 1) ? '0 : last + 1'b1;
      pend <= req_ready & ~req_we;
      pend_port <= gb_g ? gb_oh : '0;
    end
  end
  assign rsp_valid = pend;
  for (genvar i = 0; i < NREQ; i++) begin : g_rsp
    assign rsp_rdata[i*WIDTH +: WIDTH] = !pend[i] ? '0 :
                                         pend_port[i] == PORT_A ? ram_dout_a : ram_dout_b;
  end
endmodule

// File: tb/tb_dpram_port_arbiter.sv
// tb_dpram_port_arbiter: random and directed traffic against a RAM model, with a reference scoreboard.
module tb_dpram_port_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  localparam int AW = 8;
  typedef struct {int idx; logic [W-1:0] data; int cyc;} exp_t;
  logic clk = 0, rst;
  logic [N-1:0] v, we, req_ready, rsp_valid;
  logic [AW-1:0] a[N];
  logic [W-1:0] d[N];
  logic [N*AW-1:0] addr_f;
  logic [N*W-1:0] wdata_f, rsp_rdata;
  logic ram_we_a, ram_we_b;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic [W-1:0] ram_din_a, ram_din_b, ram_dout_a, ram_dout_b;
  logic [W-1:0] ram[256];
  logic [W-1:0] mem[256];
  exp_t q[$];
  int checks = 0, errors = 0, cyc = 0, mptr = 0;

  dpram_port_arbiter #(.NREQ(N), .WIDTH(W), .DEPTH(256)) dut (
    .clk(clk), .rst(rst), .req_valid(v), .req_we(we), .req_addr(addr_f), .req_wdata(wdata_f),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ram_we_a(ram_we_a), .ram_addr_a(ram_addr_a), .ram_din_a(ram_din_a), .ram_dout_a(ram_dout_a),
    .ram_we_b(ram_we_b), .ram_addr_b(ram_addr_b), .ram_din_b(ram_din_b), .ram_dout_b(ram_dout_b)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      addr_f[i*AW +: AW] = a[i];
      wdata_f[i*W +: W] = d[i];
    end
  end

  always @(posedge clk) begin
    if (ram_we_a) ram[ram_addr_a] <= ram_din_a;
    if (ram_we_b) ram[ram_addr_b] <= ram_din_b;
    ram_dout_a <= ram[ram_addr_a];
    ram_dout_b <= ram[ram_addr_b];
    cyc++;
  end

  // reference: pick two valid requesters in rotating order, drop the second on a write collision
  always @(negedge clk) begin
    int ga, gb, nw, j;
    logic [N-1:0] er;
    if (rst) begin
      checks++;
      if (req_ready !== '0 || ram_we_a !== 1'b0 || ram_we_b !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: ready=%b we_a=%b we_b=%b, required 0000/0/0", req_ready, ram_we_a, ram_we_b);
      end
      mptr = 0;
    end else begin
      ga = -1;
      gb = -1;
      for (int k = 0; k < N; k++) begin
        j = (mptr + k) % N;
        if (v[j]) begin
          if (ga < 0) ga = j;
          else if (gb < 0) gb = j;
        end
      end
      if (gb >= 0 && a[ga] == a[gb] && (we[ga] || we[gb])) gb = -1;
      er = '0;
      if (ga >= 0) er[ga] = 1'b1;
      if (gb >= 0) er[gb] = 1'b1;
      checks++;
      if (req_ready !== er) begin
        errors++;
        $display("FAIL grant @%0d: ready=%b, required %b (valid=%b we=%b ptr=%0d)", cyc, req_ready, er, v, we, mptr);
      end
      nw = 0;
      for (int i = 0; i < N; i++) if (er[i] && we[i]) nw++;
      checks++;
      if (int'(ram_we_a) + int'(ram_we_b) != nw) begin
        errors++;
        $display("FAIL ram_writes @%0d: we_a=%b we_b=%b, required %0d writes", cyc, ram_we_a, ram_we_b, nw);
      end
      for (int i = 0; i < N; i++) if (er[i] && !we[i]) q.push_back('{i, mem[a[i]], cyc + 1});
      for (int i = 0; i < N; i++) if (er[i] && we[i]) mem[a[i]] = d[i];
      if (gb >= 0) mptr = (gb + 1) % N;
      else if (ga >= 0) mptr = (ga + 1) % N;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if (rsp_valid !== '0) begin
        errors++;
        $display("FAIL rsp_in_reset: rsp_valid=%b, required 0000", rsp_valid);
      end
      q.delete();
    end else begin
      for (int i = 0; i < N; i++) if (rsp_valid[i]) begin
        checks++;
        if (q.size() == 0 || q[0].idx != i || q[0].cyc != cyc) begin
          errors++;
          $display("FAIL rsp_unexpected @%0d: requester %0d valid, required none pending", cyc, i);
        end else begin
          if (rsp_rdata[i*W +: W] !== q[0].data) begin
            errors++;
            $display("FAIL rsp_data @%0d req%0d: got %h, required %h", cyc, i, rsp_rdata[i*W +: W], q[0].data);
          end
          void'(q.pop_front());
        end
      end
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        checks++;
        errors++;
        $display("FAIL rsp_missing @%0d: requester %0d got rsp_valid=0, required 1", cyc, q[0].idx);
        void'(q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = '0;
      mem[i] = '0;
    end
    rst = 1;
    v = '0;
    we = '0;
    for (int i = 0; i < N; i++) begin
      a[i] = '0;
      d[i] = '0;
    end
    repeat (3) tick();
    rst = 0;
    repeat (2) tick();
    v = 4'b0001; we = 4'b0001; a[0] = 8'h10; d[0] = 32'hDEADBEEF;
    tick();
    v = 4'b0010; we = 4'b0000; a[1] = 8'h10;
    tick();
    v = '0;
    repeat (2) tick();
    v = 4'b0010; we = '0; a[1] = 8'h10;
    tick();
    v = '0; rst = 1;
    repeat (2) tick();
    rst = 0;
    v = 4'b1111; we = '0; a[0] = 8'h01; a[1] = 8'h02; a[2] = 8'h03; a[3] = 8'h04;
    repeat (4) tick();
    v = '0;
    tick();
    v = 4'b0011; we = 4'b0011; a[0] = 8'h20; a[1] = 8'h20; d[0] = 32'h1111_1111; d[1] = 32'h2222_2222;
    tick();
    v = 4'b0010;
    tick();
    v = 4'b0100; we = '0; a[2] = 8'h20;
    tick();
    v = 4'b0001; we = 4'b0001; a[0] = 8'h05; d[0] = 32'hA5A5_0505;
    tick();
    v = 4'b1100; we = '0; a[2] = 8'h05; a[3] = 8'h05;
    tick();
    v = '0;
    tick();
    for (int n = 0; n < 400; n++) begin
      v = N'($urandom);
      we = N'($urandom);
      for (int i = 0; i < N; i++) begin
        a[i] = AW'($urandom_range(0, 7));
        d[i] = $urandom;
      end
      tick();
    end
    v = '0;
    repeat (3) tick();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
